dict_fifo_multi: RTL
====================

# dict_fifo_multi

Multi-lane circular dictionary buffer for the compression datapath. It holds the most recent DEPTH words written on each of LANES independent write lanes. It exposes the whole dictionary flattened, with per-entry valid bits. It also gives a registered one-cycle associative search of all valid entries, which feeds the match/encode stage. It generalises the two-bank dictionary FIFO by adding:
- arbitrary lane count and depth;
- occupancy tracking;
- a flush command;
- a built-in match port.

## Interface
- DATA_WIDTH, 32, word width in bits
- LANES, 2, number of independent write lanes/banks (>=1)
- DEPTH, 8, entries per lane (>=2, any integer, not required to be power of two)
- i_clk  input  1  rising-edge clock
- i_reset  input  1  synchronous, active-high reset
- i_flush  input  1  synchronous dictionary clear (same effect as reset on all state)
- i_wr_en  input  LANES  per-lane write enable, bit l = lane l
- i_wr_data  input  LANES*DATA_WIDTH  write words, lane l at bits [l*DATA_WIDTH +: DATA_WIDTH]
- i_search_valid  input  1  search request
- i_search_data  input  DATA_WIDTH  word to look up
- o_data  output  LANES*DEPTH*DATA_WIDTH  flattened dictionary; entry e of lane l at flat index f = e*LANES + l, bits [f*DATA_WIDTH +: DATA_WIDTH]
- o_valid  output  LANES*DEPTH  entry valid bits, same flat index f
- o_count  output  LANES*$clog2(DEPTH+1)  per-lane occupancy, lane l in slice l
- o_full  output  LANES  lane l holds DEPTH valid entries
- o_match_valid  output  1  search result valid (one cycle after request)
- o_match_hit  output  1  at least one valid entry equals the searched word
- o_match_vec  output  LANES*DEPTH  per-entry match bits, flat index f
- o_match_idx  output  $clog2(LANES*DEPTH)  lowest flat index with a match; 0 when no hit

## Operation
- **Per-lane state:**
  - write pointer wp[l] in 0..DEPTH-1;
  - count[l] in 0..DEPTH;
  - DEPTH data registers and DEPTH valid bits.
- **Write (i_wr_en[l]=1, no reset/flush):**
  - entry wp[l] is loaded with lane l data and its valid bit is set;
  - wp[l] advances: DEPTH-1 wraps to 0, otherwise +1;
  - count[l] increments, saturating at DEPTH.
- **Write when full:** the oldest entry (at wp[l]) is overwritten. There is no backpressure and no error flag, which is dictionary semantics.
- **Lane independence:** lanes are fully independent. Any subset of lanes may write in the same cycle, each at its own pointer.
- **Idle lanes:** entries, pointer and count hold.
- **Priority:** i_reset > i_flush > writes. Reset and flush both clear:
  - all data registers to 0;
  - all valid bits;
  - all pointers and counts;
  - the match outputs.
  A write in the same cycle as a flush is discarded.
- **Search:**
  - in the cycle i_search_valid=1, each entry is compared with i_search_data using pre-write contents, i.e. the registered state before this cycle's edge;
  - only entries with valid=1 may match;
  - the result is registered.
- **o_match_idx:** priority-encoded, with the lowest flat index winning. Lane 0 entry 0 is the highest priority.
- **No search:** when no search is requested, o_match_valid=0 next cycle. o_match_hit, o_match_vec and o_match_idx are then driven to 0.
- **Combinational outputs:** o_full[l] = (count[l]==DEPTH). o_data, o_valid, o_count and o_full are direct register views with no combinational path from inputs.

## Timing
- **Reset values:**
  - o_data, o_valid, o_count, o_full: all 0;
  - o_match_valid, o_match_hit, o_match_vec, o_match_idx: all 0.
- **Write latency:** 1 cycle. Data is visible on o_data and o_valid after the edge that samples i_wr_en.
- **Search latency:** 1 cycle. A request at edge N gives its result during cycle N+1. Back-to-back searches give back-to-back results.
- **Search vs. same-cycle write:**
  - a search issued in the same cycle as a write does not see the new word;
  - a search one cycle later does see it;
  - a search in the same cycle as a write that overwrites entry X compares against X's old value.
- **Search during flush/reset:** a search issued in a flush or reset cycle yields o_match_valid=0.
- **Reset mid-operation:** all state clears at the next edge and pointers restart at entry 0.

## Test plan
- **Reset/fill:**
  - stimulus: reset, then lane0 writes 0xA0..0xA7 on 8 consecutive cycles (LANES=2, DEPTH=8);
  - required: o_count lane0 goes 1..8; o_full[0]=1 after the 8th write; lane1 count stays 0;
  - required: entry e of lane0 = 0xA0+e at flat index 2e.
- **Wrap/overwrite:**
  - stimulus: on the full lane0, write 0xB0;
  - required: entry 0 = 0xB0, count stays 8, wp=1; entries 1..7 are unchanged.
- **Dual-lane simultaneous write:**
  - stimulus: from reset, i_wr_en=2'b11 with data 0x11111111/0x22222222;
  - required: flat index 0 = 0x11111111, flat index 1 = 0x22222222; both counts = 1.
- **Search hit/miss and priority:**
  - stimulus: lane0 entry 2 and lane1 entry 0 both hold 0x55; search 0x55;
  - required: next cycle o_match_valid=1, hit=1, vec bits 1 and 4 set, idx=1;
  - stimulus: search 0x99;
  - required: hit=0, vec=0, idx=0.
- **Search vs. concurrent write and invalid entries:**
  - stimulus: search 0x00 after reset (data regs are 0 but invalid);
  - required: hit=0;
  - stimulus: write 0x77 and search 0x77 in the same cycle;
  - required: hit=0;
  - stimulus: repeat the search 0x77 next cycle;
  - required: hit=1.
- **Flush priority:**
  - stimulus: i_flush together with i_wr_en=2'b01 and i_search_valid;
  - required: all valid/count/full = 0, write dropped, o_match_valid=0 next cycle; the next write lands at entry 0.

Source files
------------

// File: rtl/dict_fifo_multi.sv
// dict_fifo_multi: multi-lane circular dictionary with occupancy, flush and registered associative search
module dict_fifo_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  localparam int N = LANES * DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH),
  localparam int IW = $clog2(N)
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_flush,
  input  logic [LANES-1:0]                 i_wr_en,
  input  logic [LANES*DATA_WIDTH-1:0]      i_wr_data,
  input  logic                             i_search_valid,
  input  logic [DATA_WIDTH-1:0]            i_search_data,
  output logic [N*DATA_WIDTH-1:0]          o_data,
  output logic [N-1:0]                     o_valid,
  output logic [LANES*CW-1:0]              o_count,
  output logic [LANES-1:0]                 o_full,
  output logic                             o_match_valid,
  output logic                             o_match_hit,
  output logic [N-1:0]                     o_match_vec,
  output logic [IW-1:0]                    o_match_idx
);
  logic [N-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [N-1:0]                 valid_q, valid_d;
  logic [LANES-1:0][PW-1:0]     wp_q, wp_d;
  logic [LANES-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]                widx;
  logic [N-1:0]                 cmp;
  logic [IW-1:0]                cidx;
  logic                         srch;
  logic                         mvalid_q, mvalid_d, mhit_q, mhit_d;
  logic [N-1:0]                 mvec_q, mvec_d;
  logic [IW-1:0]                midx_q, midx_d;
  // per-lane write: load entry at the lane pointer, advance pointer with wrap, saturate count
  always_comb begin
    data_d = data_q;
    valid_d = valid_q;
    wp_d = wp_q;
    cnt_d = cnt_q;
    widx = '0;
    if (i_flush) begin
      data_d = '0;
      valid_d = '0;
      wp_d = '0;
      cnt_d = '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (i_wr_en[l]) begin
          widx = IW'(int'(wp_q[l]) * LANES + l);
          data_d[widx] = i_wr_data[l*DATA_WIDTH +: DATA_WIDTH];
          valid_d[widx] = 1'b1;
          wp_d[l] = (wp_q[l] == PW'(DEPTH - 1)) ? '0 : wp_q[l] + 1'b1;
          cnt_d[l] = (cnt_q[l] == CW'(DEPTH)) ? cnt_q[l] : cnt_q[l] + 1'b1;
        end
      end
    end
  end
  // associative compare against pre-write contents; lowest flat index wins
  always_comb begin
    cmp = '0;
    cidx = '0;
    for (int f = 0; f < N; f++) cmp[f] = valid_q[f] && (data_q[f] == i_search_data);
    for (int f = N - 1; f >= 0; f--) if (cmp[f]) cidx = IW'(f);
    srch = i_search_valid && !i_flush;
    mvalid_d = srch;
    mhit_d = srch && |cmp;
    mvec_d = srch ? cmp : '0;
    midx_d = srch ? cidx : '0;
  end
  // state registers; reset clears everything including the match result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q <= '0;
      valid_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
      mvalid_q <= 1'b0;
      mhit_q <= 1'b0;
      mvec_q <= '0;
      midx_q <= '0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      mvalid_q <= mvalid_d;
      mhit_q <= mhit_d;
      mvec_q <= mvec_d;
      midx_q <= midx_d;
    end
  end
  // lane is full once it holds DEPTH valid entries
  always_comb begin
    o_full = '0;
    for (int l = 0; l < LANES; l++) o_full[l] = (cnt_q[l] == CW'(DEPTH));
  end
  assign o_data = data_q;
  assign o_valid = valid_q;
  assign o_count = cnt_q;
  assign o_match_valid = mvalid_q;
  assign o_match_hit = mhit_q;
  assign o_match_vec = mvec_q;
  assign o_match_idx = midx_q;
endmodule
